// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the 68k-style bus sequencer: address map, FSM encodings
// and UART status bit layout.
package bus_sequencer_pkg;

  localparam logic [3:0]  LOW_NIB    = 4'h0;
  localparam logic [3:0]  PROM_NIB   = 4'hF;
  localparam logic [23:0] SIG_ADDR   = 24'h100001;
  localparam logic [23:0] USTAT_ADDR = 24'h100003;
  localparam logic [23:0] UDATA_ADDR = 24'h100005;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OCC_LSB = 4;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {DT_IDLE, DT_WAIT, DT_STEP, DT_ACK, DT_HOLD, DT_ERR} dt_state_e;
  typedef enum logic [1:0] {D_IDLE, D_TRIG, D_GUARD} drain_state_e;
  typedef enum logic [1:0] {RG_MEM, RG_SIG, RG_STAT, RG_DATA} reg_e;

  typedef struct packed {
    logic rd;
    reg_e rg;
  } acc_t;

  function automatic logic [15:0] uart_status(input logic full, input logic empty,
                                               input logic busy, input logic [3:0] occ);
    logic [15:0] s;
    s               = '0;
    s[ST_FULL]      = full;
    s[ST_EMPTY]     = empty;
    s[ST_BUSY]      = busy;
    s[ST_OCC_LSB +: 4] = occ;
    return s;
  endfunction

endpackage

// File: rtl/bus_txfifo.sv
// UART transmit FIFO; pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter.
module bus_txfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          gclk_i,
  input  logic          grst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   occ_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW:0]             wptr_q, rptr_q;
  logic                    push_ok, pop_ok;

  assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = wptr_q == rptr_q;
  assign occ_o   = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(negedge gclk_i or negedge grst_ni) begin
    if (!grst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(negedge gclk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bus_sequencer.sv
// CPU bus sequencer: address decode, chip selects, DTACK/BERR generation, signal
// and UART registers, and the UART transmit drain. All state moves on MCLK falling edges.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int PROM_WS   = 2,
  parameter int SRAM_WS   = 0,
  parameter int IO_WS     = 1,
  parameter int SIG_W     = 4,
  parameter int TXF_DEPTH = 4,
  parameter int BERR_TO   = 64
) (
  input  logic             MCLK_IN,
  input  logic             RUN_IN,
  input  logic             STEPEN_IN,
  input  logic             STEP_IN,
  input  logic             AS_IN,
  input  logic             WR_IN,
  input  logic             UDS_IN,
  input  logic             LDS_IN,
  input  logic [23:0]      ADDR_IN,
  inout  wire  [15:0]      DATA,
  input  logic [SIG_W-1:0] INPUT_SIGNAL_IN,
  input  logic             UART_SEND_BUSY_IN,
  output logic             DTACK,
  output logic             BERR,
  output logic             PROMCS0,
  output logic             PROMCS1,
  output logic             SRAMCS0,
  output logic             SRAMCS1,
  output logic             OE,
  output logic [SIG_W-1:0] OUTPUT_SIGNAL,
  output logic             UART_SEND_TRIGGER,
  output logic [7:0]       UART_SEND_BYTE
);

  localparam int AW      = $clog2(TXF_DEPTH);
  localparam int SIG_LSB = (SIG_W <= 4) ? 4 : 0;

  dt_state_e         st_q;
  drain_state_e      dst_q;
  acc_t              acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              stepped_q, dtack_q, berr_q, boot_q;
  logic [SIG_W-1:0]  out_sig_q;
  logic [7:0]        last_q, byte_q;
  logic              trig_q;

  logic              dtreq, lower, upper, prom_sel, sram_sel;
  logic              is_sig, is_stat, is_data, mapped;
  logic [CNT_W-1:0]  ws;
  reg_e              rg_d;
  logic              stall, enter_ack, sig_wr, push, pop, drive;
  logic [15:0]       rdata;
  logic [7:0]        fifo_head;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_occ;

  // ---------------- decode ----------------
  assign dtreq    = RUN_IN & AS_IN & (UDS_IN | LDS_IN);
  assign lower    = ADDR_IN[23:20] == LOW_NIB;
  assign upper    = ADDR_IN[23:20] == PROM_NIB;
  assign prom_sel = upper | (lower & ~boot_q & ~WR_IN);
  assign sram_sel = lower & ~prom_sel;
  assign is_sig   = LDS_IN & (ADDR_IN == SIG_ADDR);
  assign is_stat  = LDS_IN & (ADDR_IN == USTAT_ADDR);
  assign is_data  = LDS_IN & (ADDR_IN == UDATA_ADDR);
  assign mapped   = prom_sel | sram_sel | is_sig | is_stat | is_data;

  assign PROMCS0 = AS_IN & prom_sel & UDS_IN;
  assign PROMCS1 = AS_IN & prom_sel & LDS_IN;
  assign SRAMCS0 = AS_IN & sram_sel & UDS_IN;
  assign SRAMCS1 = AS_IN & sram_sel & LDS_IN;
  assign OE      = AS_IN & (prom_sel | sram_sel) & ~WR_IN;

  always_comb begin
    ws = CNT_W'(IO_WS);
    if (prom_sel)      ws = CNT_W'(PROM_WS);
    else if (sram_sel) ws = CNT_W'(SRAM_WS);
  end

  always_comb begin
    rg_d = RG_MEM;
    if (is_sig)       rg_d = RG_SIG;
    else if (is_stat) rg_d = RG_STAT;
    else if (is_data) rg_d = RG_DATA;
  end

  // A UART data write may only complete once the FIFO has room, so no push is dropped.
  assign stall     = ~acc_q.rd & (acc_q.rg == RG_DATA) & fifo_full;
  assign enter_ack = dtreq & (((st_q == DT_WAIT) & (cnt_q == '0) & ~stall & ~STEPEN_IN) |
                              ((st_q == DT_STEP) & STEP_IN));
  assign sig_wr    = enter_ack & ~acc_q.rd & (acc_q.rg == RG_SIG);
  assign push      = enter_ack & ~acc_q.rd & (acc_q.rg == RG_DATA);

  // ---------------- DTACK / BERR FSM ----------------
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      st_q      <= DT_IDLE;
      acc_q     <= '{rd: 1'b0, rg: RG_MEM};
      cnt_q     <= '0;
      stepped_q <= 1'b0;
      dtack_q   <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      case (st_q)
        DT_IDLE: if (dtreq) begin
          acc_q     <= '{rd: ~WR_IN, rg: rg_d};
          stepped_q <= 1'b0;
          if (mapped) begin
            st_q  <= DT_WAIT;
            cnt_q <= ws;
          end else begin
            st_q  <= DT_ERR;
            cnt_q <= CNT_W'(BERR_TO - 1);
          end
        end
        DT_WAIT: begin
          if (!dtreq)              st_q <= DT_IDLE;
          else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
          else if (stall)          st_q <= DT_WAIT;
          else if (STEPEN_IN) begin
            st_q      <= DT_STEP;
            stepped_q <= 1'b1;
          end else begin
            st_q    <= DT_ACK;
            dtack_q <= 1'b1;
          end
        end
        DT_STEP: begin
          if (!dtreq) st_q <= DT_IDLE;
          else if (STEP_IN) begin
            st_q    <= DT_ACK;
            dtack_q <= 1'b1;
          end
        end
        DT_ACK: if (!dtreq) begin
          dtack_q <= 1'b0;
          st_q    <= stepped_q ? DT_HOLD : DT_IDLE;
        end
        // After a stepped cycle the switch must be released before the next access.
        DT_HOLD: if (!STEP_IN) st_q <= DT_IDLE;
        DT_ERR: begin
          if (!dtreq) begin
            berr_q <= 1'b0;
            st_q   <= DT_IDLE;
          end else if (cnt_q == '0) berr_q <= 1'b1;
          else                      cnt_q  <= cnt_q - 1'b1;
        end
        default: st_q <= DT_IDLE;
      endcase
    end
  end

  // ---------------- registers ----------------
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      boot_q    <= 1'b0;
      out_sig_q <= '0;
      last_q    <= '0;
    end else begin
      if (dtreq & WR_IN & lower) boot_q    <= 1'b1;
      if (sig_wr)                out_sig_q <= DATA[SIG_LSB +: SIG_W];
      if (push)                  last_q    <= DATA[7:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (acc_q.rg)
      RG_SIG:  rdata = 16'({out_sig_q, INPUT_SIGNAL_IN});
      RG_STAT: rdata = uart_status(fifo_full, fifo_empty, UART_SEND_BUSY_IN, 4'(fifo_occ));
      RG_DATA: rdata = {8'h00, last_q};
      default: rdata = '0;
    endcase
  end

  // Memory reads are driven by the PROM/SRAM themselves, never by this block.
  assign drive = (st_q == DT_ACK) & acc_q.rd & (acc_q.rg != RG_MEM);
  assign DATA  = drive ? rdata : 16'bz;

  // ---------------- UART drain ----------------
  assign pop = (dst_q == D_IDLE) & ~fifo_empty & ~UART_SEND_BUSY_IN;

  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      dst_q  <= D_IDLE;
      trig_q <= 1'b0;
      byte_q <= '0;
    end else begin
      case (dst_q)
        D_IDLE: if (pop) begin
          dst_q  <= D_TRIG;
          byte_q <= fifo_head;
          trig_q <= 1'b1;
        end
        D_TRIG: begin
          trig_q <= 1'b0;
          dst_q  <= D_GUARD;
        end
        // One dead cycle lets the transmitter raise busy before we look again.
        D_GUARD: dst_q <= D_IDLE;
        default: dst_q <= D_IDLE;
      endcase
    end
  end

  bus_txfifo #(.W(8), .DEPTH(TXF_DEPTH)) u_txf (
    .gclk_i  (MCLK_IN),
    .grst_ni (RUN_IN),
    .push_i  (push),
    .wdata_i (DATA[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .occ_o   (fifo_occ)
  );

  assign DTACK             = dtack_q;
  assign BERR              = berr_q;
  assign OUTPUT_SIGNAL     = out_sig_q;
  assign UART_SEND_TRIGGER = trig_q;
  assign UART_SEND_BYTE    = byte_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: decode, wait states, UART FIFO stall/drain,
// bus error timeout, stepping and mid-access reset.
module tb_bus_sequencer;

  localparam int SIG_W = 4;

  logic             mclk = 1'b0;
  logic             run, stepen, step, as, wr, uds, lds, busy;
  logic [23:0]      addr;
  tri1  [15:0]      data;
  logic [15:0]      tb_dout;
  logic             tb_den;
  logic [SIG_W-1:0] insig, outsig;
  logic             dtack, berr, pcs0, pcs1, scs0, scs1, oe, trig;
  logic [7:0]       ubyte;
  int               n_chk = 0;
  int               n_err = 0;

  assign data = tb_den ? tb_dout : 16'bz;

  always #5 mclk = ~mclk;

  bus_sequencer #(
    .PROM_WS(2), .SRAM_WS(0), .IO_WS(1), .SIG_W(SIG_W), .TXF_DEPTH(4), .BERR_TO(64)
  ) dut (
    .MCLK_IN(mclk), .RUN_IN(run), .STEPEN_IN(stepen), .STEP_IN(step),
    .AS_IN(as), .WR_IN(wr), .UDS_IN(uds), .LDS_IN(lds), .ADDR_IN(addr),
    .DATA(data), .INPUT_SIGNAL_IN(insig), .UART_SEND_BUSY_IN(busy),
    .DTACK(dtack), .BERR(berr), .PROMCS0(pcs0), .PROMCS1(pcs1),
    .SRAMCS0(scs0), .SRAMCS1(scs1), .OE(oe), .OUTPUT_SIGNAL(outsig),
    .UART_SEND_TRIGGER(trig), .UART_SEND_BYTE(ubyte)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic bus_begin(input logic [23:0] a, input logic w, input logic u,
                           input logic l, input logic [15:0] d);
    @(posedge mclk);
    addr = a; wr = w; uds = u; lds = l; tb_dout = d; tb_den = w; as = 1'b1;
  endtask

  task automatic bus_end();
    as = 1'b0; uds = 1'b0; lds = 1'b0; wr = 1'b0; tb_den = 1'b0;
  endtask

  // Counts rising edges until DTACK is seen; n-1 is the number of falling edges
  // after the one that first sampled the request.
  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (!dtack && n < max) begin
      @(posedge mclk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         n;
    logic       seen, zok, acked;
    logic [7:0] q[$];

    run = 0; stepen = 0; step = 0; as = 0; wr = 0; uds = 0; lds = 0;
    addr = '0; tb_dout = '0; tb_den = 0; insig = 4'hA; busy = 0;

    repeat (3) @(posedge mclk);
    #1;
    chk("rst_dtack", dtack, 0);
    chk("rst_berr", berr, 0);
    chk("rst_sig", outsig, 0);
    chk("rst_trig", trig, 0);
    chk("rst_byte", ubyte, 0);
    chk("rst_data_z", data, 16'hFFFF);
    @(posedge mclk); run = 1;

    // Lower area reads come from PROM until the first write there.
    bus_begin(24'h000010, 0, 1, 1, 16'h0); #1;
    chk("boot_pcs0", pcs0, 1);
    chk("boot_scs0", scs0, 0);
    wait_ack(10, n);
    chk("boot_lat", n - 1, 3);
    bus_end();

    bus_begin(24'hF00000, 0, 1, 1, 16'h0); #1;
    chk("prom_cs", {pcs0, pcs1, oe, scs0, scs1}, 5'b11100);
    wait_ack(10, n);
    chk("prom_lat", n - 1, 3);
    chk("prom_data_z", data, 16'hFFFF);
    bus_end();
    @(posedge mclk); #1;
    chk("ack_neg", dtack, 0);

    bus_begin(24'h000010, 1, 1, 1, 16'h1234); #1;
    chk("sram_wr_cs", {pcs0, pcs1, oe, scs0, scs1}, 5'b00011);
    wait_ack(10, n);
    chk("sram_wr_lat", n - 1, 1);
    bus_end();
    bus_begin(24'h000010, 0, 1, 1, 16'h0); #1;
    chk("sram_rd_cs", {pcs0, pcs1, oe, scs0, scs1}, 5'b00111);
    wait_ack(10, n);
    chk("sram_rd_lat", n - 1, 1);
    bus_end();

    // UART: fill the 4-deep FIFO with the transmitter busy.
    busy = 1;
    for (int i = 0; i < 4; i++) begin
      bus_begin(24'h100005, 1, 0, 1, 16'(16'h0041 + i));
      wait_ack(10, n);
      chk("tx_lat", n - 1, 2);
      bus_end();
    end
    // busy is still high, so bit2 is set next to full and occupancy 4.
    bus_begin(24'h100003, 0, 0, 1, 16'h0);
    wait_ack(10, n);
    chk("st_full", data, 16'h0045);
    bus_end();
    bus_begin(24'h100005, 0, 0, 1, 16'h0);
    wait_ack(10, n);
    chk("udata_rd", data, 16'h0044);
    bus_end();

    bus_begin(24'h100005, 1, 0, 1, 16'h0045);
    seen = 0;
    repeat (15) begin
      @(posedge mclk);
      if (dtack) seen = 1;
    end
    chk("tx_stall", seen, 0);
    busy = 0; acked = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge mclk);
      if (trig) q.push_back(ubyte);
      if (dtack && as) begin
        acked = 1;
        bus_end();
      end
    end
    chk("stall_release", acked, 1);
    chk("trig_cnt", q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("trig_byte", (i < q.size()) ? 32'(q[i]) : 32'hFFFF, 32'(8'h41 + i));

    // Unmapped access times out with BERR and never acknowledges.
    bus_begin(24'h200000, 0, 1, 1, 16'h0); #1;
    chk("um_cs", {pcs0, pcs1, oe, scs0, scs1}, 5'b00000);
    n = 0; seen = 0; zok = 1;
    while (!berr && n < 100) begin
      @(posedge mclk);
      n++;
      if (dtack) seen = 1;
      if (data !== 16'hFFFF) zok = 0;
    end
    chk("berr_lat", n - 1, 64);
    chk("berr_dtack", seen, 0);
    chk("berr_data_z", zok, 1);
    repeat (3) @(posedge mclk);
    chk("berr_hold", berr, 1);
    bus_end();
    @(posedge mclk); #1;
    chk("berr_neg", berr, 0);

    // Signal register write, then a stepped read of it.
    bus_begin(24'h100001, 1, 0, 1, 16'h00B0);
    wait_ack(10, n);
    chk("sig_lat", n - 1, 2);
    chk("sig_out", outsig, 4'hB);
    bus_end();

    stepen = 1;
    bus_begin(24'h100001, 0, 0, 1, 16'h0);
    seen = 0;
    repeat (10) begin
      @(posedge mclk);
      if (dtack) seen = 1;
    end
    chk("step_held", seen, 0);
    step = 1;
    @(posedge mclk);
    chk("step_ack", dtack, 1);
    chk("step_rd", data, 16'h00BA);
    bus_end();
    stepen = 0;
    bus_begin(24'h100003, 0, 0, 1, 16'h0);
    seen = 0;
    repeat (10) begin
      @(posedge mclk);
      if (dtack) seen = 1;
    end
    chk("hold_block", seen, 0);
    step = 0;
    wait_ack(10, n);
    chk("hold_rel_lat", n, 4);
    chk("st_empty", data, 16'h0002);
    bus_end();

    // Reset in the middle of a signal write aborts it.
    bus_begin(24'h100001, 1, 0, 1, 16'h0070);
    @(posedge mclk);
    chk("pre_rst_sig", outsig, 4'hB);
    chk("pre_rst_byte", ubyte, 8'h45);
    run = 0; #1;
    chk("mid_rst_dtack", dtack, 0);
    chk("mid_rst_berr", berr, 0);
    chk("mid_rst_sig", outsig, 0);
    chk("mid_rst_trig", trig, 0);
    chk("mid_rst_byte", ubyte, 0);
    repeat (3) @(posedge mclk);
    bus_end();
    @(posedge mclk); run = 1;
    repeat (3) @(posedge mclk); #1;
    chk("post_rst_sig", outsig, 0);
    chk("post_rst_data_z", data, 16'hFFFF);
    bus_begin(24'h000010, 0, 1, 1, 16'h0); #1;
    chk("post_rst_boot", {pcs0, scs0}, 2'b10);
    wait_ack(10, n);
    chk("post_rst_lat", n - 1, 3);
    bus_end();
    repeat (2) @(posedge mclk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
